// File: rtl/krake_bus_master.sv
// Krake register-bus initiator: one command in, one strobed bus cycle out, one response back.
// Optional timeout/abort path enabled by defining KRAKE_MASTER_TIMEOUT_EN.
module krake_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [3:0] cmd_adr,
  input  logic [7:0] cmd_dat,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_dat,
  output logic       rsp_err,
  output logic       stb_o,
  output logic       we_o,
  output logic [3:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_dat_q, rsp_dat_d;
  logic       rsp_err_q, rsp_err_d;
  logic       stb_q, stb_d;
  logic       we_q, we_d;
  logic [3:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;

`ifdef KRAKE_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output computation; every output is the registered copy of its _d.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    stb_d       = 1'b0;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
`ifdef KRAKE_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_STROBE;
          cmd_ready_d = 1'b0;
          stb_d       = 1'b1;
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      ST_STROBE: begin
        state_d = ST_WAIT;
`ifdef KRAKE_MASTER_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end

      ST_WAIT: begin
        // An ack wins over a timeout expiring in the same cycle.
        if (ack_i) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? 8'd0 : dat_i;
          rsp_err_d   = 1'b0;
        end else begin
`ifdef KRAKE_MASTER_TIMEOUT_EN
          if (cnt_q == TIMEOUT_LAST) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_dat_d   = 8'd0;
            rsp_err_d   = 1'b1;
          end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_dat_d   = 8'd0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          we_d        = 1'b0;
          adr_d       = 4'd0;
          dat_d       = 8'd0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = 8'd0;
        rsp_err_d   = 1'b0;
        we_d        = 1'b0;
        adr_d       = 4'd0;
        dat_d       = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 8'd0;
      rsp_err_q   <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 4'd0;
      dat_q       <= 8'd0;
`ifdef KRAKE_MASTER_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
`ifdef KRAKE_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign stb_o     = stb_q;
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;

endmodule

// File: tb/tb_krake_bus_master.sv
// Directed bench for krake_bus_master: table of single transactions plus hand-written
// back-to-back, reset-during-WAIT and (with KRAKE_MASTER_TIMEOUT_EN) timeout sequences.
module tb_krake_bus_master;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [3:0] cmd_adr = 4'd0;
  logic [7:0] cmd_dat = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_dat;
  logic       rsp_err;
  logic       stb_o;
  logic       we_o;
  logic [3:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i = 8'd0;
  logic       ack_i = 1'b0;

  krake_bus_master #(.TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
    int         ack_dly;   // windows after the accept edge before ack; 255 = never
    logic [7:0] rdat;
    int         hold;      // windows rsp_ready stays low once the response is up
    logic [7:0] exp_dat;
    logic       exp_err;
    int         exp_lat;   // edges from accept to rsp_valid visible
  } vec_t;

  vec_t vecs [8];
  int   n_vec;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {cmd_ready, rsp_valid, rsp_dat, rsp_err, stb_o, we_o, adr_o, dat_o},
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00});
  endtask

  task automatic do_cmd(input vec_t v, input string tag);
    int guard;
    int lat;
    int extra_stb;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk($sformatf("%s_ready", tag), {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat;
    tick();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 4'h0; cmd_dat = 8'h00;
    chk($sformatf("%s_strobe", tag), {stb_o, cmd_ready, we_o, adr_o, dat_o},
        {1'b1, 1'b0, v.we, v.adr, v.dat});
    lat = 0;
    extra_stb = 0;
    while (!rsp_valid && lat < 40) begin
      if (lat == v.ack_dly) begin
        ack_i = 1'b1; dat_i = v.rdat;
      end else begin
        ack_i = 1'b0; dat_i = 8'h00;
      end
      tick();
      lat++;
      if (stb_o) extra_stb++;
    end
    ack_i = 1'b0; dat_i = 8'h00;
    chk($sformatf("%s_latency", tag), lat, v.exp_lat);
    chk($sformatf("%s_extra_stb", tag), extra_stb, 32'd0);
    chk($sformatf("%s_rsp", tag), {rsp_valid, rsp_err, rsp_dat}, {1'b1, v.exp_err, v.exp_dat});
    chk($sformatf("%s_bus_held", tag), {we_o, adr_o, dat_o}, {v.we, v.adr, v.dat});
    for (int h = 0; h < v.hold; h++) begin
      rsp_ready = 1'b0;
      tick();
      chk($sformatf("%s_hold%0d", tag, h), {rsp_valid, rsp_err, rsp_dat, cmd_ready},
          {1'b1, v.exp_err, v.exp_dat, 1'b0});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk($sformatf("%s_release", tag), {rsp_valid, cmd_ready, we_o, adr_o, dat_o},
        {1'b0, 1'b1, 1'b0, 4'h0, 8'h00});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          pulse_w [3];
    logic [7:0]  rsp_seen [3];
    logic [3:0]  b2b_adr [3];
    int          n_pulse;
    int          n_rsp;
    int          n_acc;
    logic        stb_last;

    // we  adr    dat     ack  rdat   hold exp_dat exp_err lat
    vecs[0] = '{1'b1, 4'h1, 8'h3F, 1, 8'h00, 0, 8'h00, 1'b0, 2};
    vecs[1] = '{1'b0, 4'h0, 8'h00, 1, 8'h2A, 5, 8'h2A, 1'b0, 2};
    vecs[2] = '{1'b0, 4'h7, 8'h00, 3, 8'hC3, 1, 8'hC3, 1'b0, 4};
    vecs[3] = '{1'b1, 4'hF, 8'hA5, 2, 8'hFF, 0, 8'h00, 1'b0, 3};
    vecs[4] = '{1'b0, 4'h9, 8'h00, 1, 8'h00, 2, 8'h00, 1'b0, 2};
    n_vec = 5;
`ifdef KRAKE_MASTER_TIMEOUT_EN
    vecs[5] = '{1'b0, 4'hE, 8'h00, 15, 8'h55, 0, 8'h55, 1'b0, 16};
    vecs[6] = '{1'b0, 4'h2, 8'h00, 16, 8'h66, 1, 8'h00, 1'b1, 16};
    n_vec = 7;
`endif

    rst_i = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset_state");
    rst_i = 1'b0;
    tick();
    chk_reset_outputs("idle_after_reset");

    for (int i = 0; i < n_vec; i++) begin
      do_cmd(vecs[i], $sformatf("v%0d", i));
    end

`ifdef KRAKE_MASTER_TIMEOUT_EN
    // Read with no ack at all, then a late ack two windows after the response.
    do_cmd('{1'b0, 4'hF, 8'h00, 255, 8'h00, 0, 8'h00, 1'b1, 16}, "timeout");
    ack_i = 1'b1; dat_i = 8'h77;
    tick();
    ack_i = 1'b0; dat_i = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("late_ack_quiet%0d", k), {rsp_valid, stb_o, cmd_ready}, {1'b0, 1'b0, 1'b1});
    end
`endif

    // Three reads with cmd_valid held high and rsp_ready tied high.
    b2b_adr[0] = 4'h3; b2b_adr[1] = 4'h5; b2b_adr[2] = 4'hC;
    n_pulse = 0; n_rsp = 0; n_acc = 0; stb_last = 1'b0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = b2b_adr[0]; cmd_dat = 8'h00;
    for (int w = 0; w < 12; w++) begin
      ack_i = stb_last;
      dat_i = stb_last ? {4'hB, adr_o} : 8'h00;
      stb_last = stb_o;
      if (cmd_valid && cmd_ready) n_acc++;
      tick();
      if (n_acc >= 3) cmd_valid = 1'b0;
      else cmd_adr = b2b_adr[n_acc];
      if (stb_o) begin
        if (n_pulse < 3) pulse_w[n_pulse] = w;
        n_pulse++;
      end
      if (rsp_valid) begin
        if (n_rsp < 3) rsp_seen[n_rsp] = rsp_dat;
        n_rsp++;
      end
      chk($sformatf("b2b_cmd_ready_w%0d", w), {31'd0, cmd_ready}, {31'd0, (w % 4 == 3)});
    end
    ack_i = 1'b0; dat_i = 8'h00; rsp_ready = 1'b0;
    chk("b2b_pulse_count", n_pulse, 32'd3);
    chk("b2b_rsp_count", n_rsp, 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < n_pulse) chk($sformatf("b2b_pulse%0d_pos", k), pulse_w[k], 4 * k);
      if (k < n_rsp) chk($sformatf("b2b_rsp%0d", k), rsp_seen[k], {4'hB, b2b_adr[k]});
    end

    // Reset while waiting for ack, stray ack afterwards, then a normal write.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 4'h6; cmd_dat = 8'h99;
    tick();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 4'h0; cmd_dat = 8'h00;
    tick();
    chk("rst_pre_wait", {stb_o, cmd_ready, we_o, adr_o, dat_o}, {1'b0, 1'b0, 1'b1, 4'h6, 8'h99});
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_reset_outputs("rst_mid_wait");
    ack_i = 1'b1; dat_i = 8'hEE;
    tick();
    ack_i = 1'b0; dat_i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_quiet%0d", k), {rsp_valid, stb_o, cmd_ready}, {1'b0, 1'b0, 1'b1});
      tick();
    end
    do_cmd('{1'b1, 4'hA, 8'h5C, 1, 8'h00, 0, 8'h00, 1'b0, 2}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
